// File: rtl/fifo_pkg.sv
// +--------------------------------------------------------------------+
// | fifo_pkg : shared sizing helpers and types for the FIFO family     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int FIFO_DEPTH = depth_of(FIFO_ADDR_W);

  // One extra bit so the count can represent a completely full buffer.
  typedef logic [clog2(FIFO_DEPTH):0] fifo_count_t;

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// +--------------------------------------------------------------------+
// | fifo_ram : simple dual-port RAM, sync write, registered sync read  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fifo_sync_thresh.sv
// +--------------------------------------------------------------------+
// | fifo_sync_thresh : single-clock FIFO with count, thresholds,       |
// | registered read data, flush and sticky error flags.   Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_sync_thresh
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AFULL_TH  = 2**ADDR_W - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_set;
  logic w_unf_set;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance looks only at registered flags; a flush swallows both requests.
  assign w_wr_acc  = wr_en & ~w_full  & ~clear;
  assign w_rd_acc  = rd_en & ~w_empty & ~clear;
  assign w_ovf_set = wr_en & w_full  & ~clear;
  assign w_unf_set = rd_en & w_empty & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new violation outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr),
    .rd_data (rd_data)
  );

  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CNT_W'(AFULL_TH));
  assign almost_empty = (r_count <= CNT_W'(AEMPTY_TH));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_thresh.sv
// +--------------------------------------------------------------------+
// | tb_fifo_sync_thresh : directed bench with read-data scoreboard     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fifo_sync_thresh;
  import fifo_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic        err_clr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  fifo_count_t count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int mcount = 0;
  bit mov = 0;
  bit mun = 0;

  fifo_sync_thresh #(
    .DATA_W    (8),
    .ADDR_W    (4),
    .AFULL_TH  (14),
    .AEMPTY_TH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every presented word must match the oldest expected one.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_valid_unexpected: got data %0h expected no output at %0t", rd_data, $time);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_flags();
    check("count", count, mcount);
    check("full", full, mcount == DEPTH);
    check("empty", empty, mcount == 0);
    check("almost_full", almost_full, mcount >= 14);
    check("almost_empty", almost_empty, mcount <= 2);
    check("overflow", overflow, mov);
    check("underflow", underflow, mun);
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit clr, input bit ec);
    bit wacc, racc, ovs, uns;
    wr_en = w; wr_data = d; rd_en = r; clear = clr; err_clr = ec;
    wacc = w && (mcount < DEPTH) && !clr;
    racc = r && (mcount > 0) && !clr;
    ovs  = w && (mcount == DEPTH) && !clr;
    uns  = r && (mcount == 0) && !clr;
    @(posedge clk);
    #1;
    if (clr) begin
      mq.delete();
      mcount = 0;
    end
    if (racc) begin
      exp_q.push_back(mq.pop_front());
      mcount--;
    end
    if (wacc) begin
      mq.push_back(d);
      mcount++;
    end
    mov = ovs ? 1'b1 : (ec ? 1'b0 : mov);
    mun = uns ? 1'b1 : (ec ? 1'b0 : mun);
    check("rd_valid", rd_valid, racc);
    check_flags();
    wr_en = 0; rd_en = 0; clear = 0; err_clr = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_aempty"}, almost_empty, 1);
    check({tag, "_afull"}, almost_full, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_underflow"}, underflow, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int written;
    int guard;
    bit w, r;
    reset_n = 0; clear = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = 0;
    #3;
    check_reset_values("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;

    // Fill 0x00..0x0F with almost_full boundary at 14.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 12) check("afull_at_13", almost_full, 0);
      if (i == 13) check("afull_at_14", almost_full, 1);
    end
    check("fill_count", count, 16);
    check("fill_full", full, 1);

    step(1, 8'hFF, 0, 0, 0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);

    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    check("drain_empty", empty, 1);

    step(0, 8'h00, 1, 0, 0);
    check("unf_flag", underflow, 1);

    // err_clr alongside a fresh underflow: underflow stays, overflow clears.
    step(0, 8'h00, 1, 0, 1);
    check("errclr_unf_kept", underflow, 1);
    check("errclr_ovf_cleared", overflow, 0);
    step(0, 8'h00, 0, 0, 1);
    check("errclr_unf_cleared", underflow, 0);

    for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    check("sim0_count", count, 1);
    step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h90 + i), 1, 0, 0);
    check("sim8_count", count, 8);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'hE0 + i), 1, 0, 0);
    check("sim16_count", count, 15);
    check("sim16_ovf", overflow, 1);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Random stream of 100 words through the wrapping pointers.
    written = 0;
    guard = 0;
    while (written < 100 && guard < 2000) begin
      w = 1'($urandom);
      r = 1'($urandom);
      if (w && mcount < DEPTH) written++;
      step(w, 8'($urandom), r, 0, 0);
      guard++;
    end
    check("stream_done", written, 100);
    while (mcount > 0) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
    step(1, 8'h77, 1, 1, 0);
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_rd_valid", rd_valid, 0);
    check("clr_ovf", overflow, 0);
    check("clr_unf", underflow, 0);
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Reset between edges while a read is in flight.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    step(1, 8'h33, 1, 0, 0);
    #1;
    reset_n = 0;
    #1;
    exp_q.delete();
    mq.delete();
    mcount = 0; mov = 0; mun = 0;
    check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    step(0, 8'h00, 0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
